// File: rtl/riscv_mem_arbiter.sv
// Arbitrates the fetch and data requesters onto a single memory port.
// Data has priority; a streak counter eventually forces a waiting fetch through.
module riscv_mem_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_ack_o,
  output logic [31:0] instr_rd_data_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_wr_i,
  input  logic [1:0]  data_byte_en_i,
  input  logic [31:0] data_wr_data_i,
  output logic        data_ack_o,
  output logic [31:0] data_rd_data_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_wr_o,
  output logic [1:0]  mem_byte_en_o,
  output logic [31:0] mem_wr_data_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rd_data_i
);

  typedef enum logic [1:0] {IDLE, INSTR_BUSY, DATA_BUSY} state_e;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);
  localparam bit         TMO_EN     = (TIMEOUT_CYCLES != 0);

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_wr_q, mem_wr_d;
  logic [1:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        instr_ack_q, instr_ack_d;
  logic [31:0] instr_rdata_q, instr_rdata_d;
  logic        data_ack_q, data_ack_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        err_q, err_d;
  logic        instr_elig, data_elig;

  // A requester being acked this cycle is still holding its old request.
  assign instr_elig = instr_req_i & ~instr_ack_q;
  assign data_elig  = data_req_i  & ~data_ack_q;

  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    tmo_d         = tmo_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_d      = mem_wr_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    instr_ack_d   = 1'b0;
    instr_rdata_d = '0;
    data_ack_d    = 1'b0;
    data_rdata_d  = '0;
    err_d         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (data_elig && (!instr_elig || streak_q < MAX_STREAK)) begin
          state_d     = DATA_BUSY;
          mem_req_d   = 1'b1;
          mem_addr_d  = data_addr_i;
          mem_wr_d    = data_wr_i;
          mem_be_d    = data_byte_en_i;
          mem_wdata_d = data_wr_data_i;
          tmo_d       = '0;
          if (!instr_req_i)          streak_d = '0;
          else if (streak_q != 4'hF) streak_d = streak_q + 4'd1;
        end else if (instr_elig) begin
          state_d     = INSTR_BUSY;
          mem_req_d   = 1'b1;
          mem_addr_d  = instr_addr_i;
          mem_wr_d    = 1'b0;
          mem_be_d    = 2'b11;
          mem_wdata_d = '0;
          tmo_d       = '0;
          streak_d    = '0;
        end
      end
      INSTR_BUSY, DATA_BUSY: begin
        if (mem_ack_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == INSTR_BUSY) begin
            instr_ack_d   = 1'b1;
            instr_rdata_d = mem_rd_data_i;
          end else begin
            data_ack_d   = 1'b1;
            data_rdata_d = mem_wr_q ? 32'd0 : mem_rd_data_i;
          end
        end else if (TMO_EN && tmo_q == TMO_LAST) begin
          // Abort: ack the owner with an error and no data.
          state_d   = IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == INSTR_BUSY) instr_ack_d = 1'b1;
          else                       data_ack_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      streak_q      <= '0;
      tmo_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_q      <= 1'b0;
      mem_be_q      <= '0;
      mem_wdata_q   <= '0;
      instr_ack_q   <= 1'b0;
      instr_rdata_q <= '0;
      data_ack_q    <= 1'b0;
      data_rdata_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      tmo_q         <= tmo_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_q      <= mem_wr_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
      instr_ack_q   <= instr_ack_d;
      instr_rdata_q <= instr_rdata_d;
      data_ack_q    <= data_ack_d;
      data_rdata_q  <= data_rdata_d;
      err_q         <= err_d;
    end
  end

  assign instr_ack_o     = instr_ack_q;
  assign instr_rd_data_o = instr_rdata_q;
  assign data_ack_o      = data_ack_q;
  assign data_rd_data_o  = data_rdata_q;
  assign err_o           = err_q;
  assign mem_req_o       = mem_req_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_wr_o        = mem_wr_q;
  assign mem_byte_en_o   = mem_be_q;
  assign mem_wr_data_o   = mem_wdata_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: directed scenarios with literal expectations,
// then random traffic, all tracked by a transaction-level model checked every cycle.
module tb_riscv_mem_arbiter;
  localparam int MAXS = 2;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_req = 1'b0, data_req = 1'b0, data_wr = 1'b0, mem_ack = 1'b0;
  logic [31:0] instr_addr = '0, data_addr = '0, data_wd = '0, mem_rd = '0;
  logic [1:0]  data_be = 2'b11;
  logic        instr_ack_o, data_ack_o, err_o, mem_req_o, mem_wr_o;
  logic [31:0] instr_rd_data_o, data_rd_data_o, mem_addr_o, mem_wr_data_o;
  logic [1:0]  mem_byte_en_o;

  int n_cmp = 0, n_bad = 0;

  riscv_mem_arbiter #(.MAX_DATA_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr),
    .instr_ack_o(instr_ack_o), .instr_rd_data_o(instr_rd_data_o),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_wr_i(data_wr),
    .data_byte_en_i(data_be), .data_wr_data_i(data_wd),
    .data_ack_o(data_ack_o), .data_rd_data_o(data_rd_data_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wr_o(mem_wr_o),
    .mem_byte_en_o(mem_byte_en_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_ack_i(mem_ack), .mem_rd_data_i(mem_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: owner of the port (0 none, 1 fetch, 2 data), the latched
  // transaction, busy cycles spent so far, and the data-win streak.
  int          m_owner = 0, m_busy = 0, m_streak = 0;
  bit          mdl_ok = 1'b0;
  logic        e_mreq = 0, e_mwr = 0, e_iack = 0, e_dack = 0, e_err = 0;
  logic [31:0] e_maddr = 0, e_mwd = 0, e_ird = 0, e_drd = 0;
  logic [1:0]  e_mbe = 0;

  task automatic finish_txn(input bit timed_out);
    if (m_owner == 1) begin
      e_iack = 1'b1;
      e_ird  = timed_out ? 32'd0 : mem_rd;
    end else begin
      e_dack = 1'b1;
      e_drd  = (timed_out || e_mwr) ? 32'd0 : mem_rd;
    end
    e_err   = timed_out;
    e_mreq  = 1'b0;
    m_owner = 0;
  endtask

  initial begin
    bit ie, de;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_owner = 0; m_busy = 0; m_streak = 0;
        e_mreq = 0; e_maddr = 0; e_mwr = 0; e_mbe = 0; e_mwd = 0;
        e_iack = 0; e_ird = 0; e_dack = 0; e_drd = 0; e_err = 0;
        mdl_ok = 1'b1;
      end else begin
        ie = instr_req && !e_iack;
        de = data_req && !e_dack;
        e_iack = 0; e_dack = 0; e_err = 0; e_ird = 0; e_drd = 0;
        if (m_owner == 0) begin
          if (de && (!ie || m_streak < MAXS)) begin
            m_owner = 2; m_busy = 0; e_mreq = 1;
            e_maddr = data_addr; e_mwr = data_wr; e_mbe = data_be; e_mwd = data_wd;
            m_streak = instr_req ? ((m_streak == 15) ? 15 : m_streak + 1) : 0;
          end else if (ie) begin
            m_owner = 1; m_busy = 0; e_mreq = 1;
            e_maddr = instr_addr; e_mwr = 0; e_mbe = 2'b11; e_mwd = 0;
            m_streak = 0;
          end
        end else if (mem_ack) begin
          finish_txn(1'b0);
        end else begin
          m_busy++;
          if (TMO != 0 && m_busy == TMO) finish_txn(1'b1);
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (mdl_ok) begin
        chk("mem_req", mem_req_o, e_mreq);
        chk("instr_ack", instr_ack_o, e_iack);
        chk("data_ack", data_ack_o, e_dack);
        chk("err", err_o, e_err);
        if (e_mreq) begin
          chk("mem_addr", mem_addr_o, e_maddr);
          chk("mem_wr", mem_wr_o, e_mwr);
          chk("mem_be", mem_byte_en_o, e_mbe);
          chk("mem_wdata", mem_wr_data_o, e_mwd);
        end
        if (e_iack) chk("instr_rdata", instr_rd_data_o, e_ird);
        if (e_dack) chk("data_rdata", data_rd_data_o, e_drd);
      end
    end
  end

  task automatic wait_ack(input bit is_data, output int n);
    n = 0;
    while ((is_data ? data_ack_o : instr_ack_o) !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_ack: no ack within %0d cycles (is_data=%0d)", n, is_data);
    end
  endtask

  initial begin
    int n, r;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_acks", {instr_ack_o, data_ack_o, err_o}, 0);
    chk("rst_addr", mem_addr_o, 0);
    reset = 1'b0;

    // Single fetch, memory acks 3 cycles after the request appears
    @(negedge clk); instr_req = 1; instr_addr = 32'h1000; mem_ack = 0;
    @(negedge clk);
    chk("f_mem_req", mem_req_o, 1);
    chk("f_addr", mem_addr_o, 32'h1000);
    chk("f_wr", mem_wr_o, 0);
    chk("f_be", mem_byte_en_o, 2'b11);
    repeat (3) @(negedge clk);
    mem_ack = 1; mem_rd = 32'h00500093;
    @(negedge clk);
    chk("f_ack", instr_ack_o, 1);
    chk("f_rdata", instr_rd_data_o, 32'h00500093);
    chk("f_req_drop", mem_req_o, 0);
    instr_req = 0; mem_ack = 0;

    // Simultaneous requests, zero-wait memory: data write first, then fetch
    @(negedge clk);
    instr_req = 1; instr_addr = 32'h3000;
    data_req = 1; data_addr = 32'h2000; data_wr = 1; data_be = 2'b11; data_wd = 32'hDEADBEEF;
    mem_ack = 1; mem_rd = 32'h11111111;
    @(negedge clk);
    chk("s_wr", mem_wr_o, 1);
    chk("s_addr", mem_addr_o, 32'h2000);
    chk("s_wdata", mem_wr_data_o, 32'hDEADBEEF);
    @(negedge clk);
    chk("s_dack", data_ack_o, 1);
    chk("s_drdata", data_rd_data_o, 0);
    data_req = 0;
    @(negedge clk);
    chk("s_fetch_req", mem_req_o, 1);
    chk("s_fetch_addr", mem_addr_o, 32'h3000);
    chk("s_fetch_wr", mem_wr_o, 0);
    @(negedge clk);
    chk("s_iack", instr_ack_o, 1);
    chk("s_irdata", instr_rd_data_o, 32'h11111111);
    instr_req = 0; mem_ack = 0; data_wr = 0;

    // Timeout on a data read: 8 busy cycles then error ack
    @(negedge clk); data_req = 1; data_addr = 32'h4000;
    n = 0;
    @(negedge clk);
    while (mem_req_o === 1'b1 && n < 20) begin n++; @(negedge clk); end
    chk("t_busy_cycles", n, TMO);
    chk("t_dack", data_ack_o, 1);
    chk("t_err", err_o, 1);
    chk("t_drdata", data_rd_data_o, 0);
    data_addr = 32'h4004; mem_ack = 1; mem_rd = 32'h12345678;
    @(negedge clk); wait_ack(1'b1, n);
    chk("t2_err", err_o, 0);
    chk("t2_drdata", data_rd_data_o, 32'h12345678);
    data_req = 0; mem_ack = 0;

    // Ack on exactly the last busy cycle beats the timeout
    @(negedge clk); data_req = 1; data_addr = 32'h5000;
    repeat (8) @(negedge clk);
    chk("a8_still_busy", mem_req_o, 1);
    mem_ack = 1; mem_rd = 32'hCAFEF00D;
    @(negedge clk);
    chk("a8_dack", data_ack_o, 1);
    chk("a8_err", err_o, 0);
    chk("a8_drdata", data_rd_data_o, 32'hCAFEF00D);
    data_req = 0; mem_ack = 0;

    // Reset two cycles into a data transaction
    @(negedge clk); data_req = 1; data_addr = 32'h6000;
    repeat (2) @(negedge clk);
    reset = 1; data_req = 0;
    @(negedge clk);
    chk("r_mem_req", mem_req_o, 0);
    chk("r_acks", {instr_ack_o, data_ack_o, err_o}, 0);
    reset = 0;
    repeat (3) begin @(negedge clk); chk("r_no_dack", data_ack_o, 0); end
    instr_req = 1; instr_addr = 32'h7000; mem_ack = 1; mem_rd = 32'hA5A5A5A5;
    @(negedge clk); wait_ack(1'b0, n);
    chk("r_irdata", instr_rd_data_o, 32'hA5A5A5A5);
    chk("r_err", err_o, 0);
    instr_req = 0;

    // Streak guard: two data wins with fetch present, then fetch must win
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); data_req = 1; data_addr = 32'h8000 + 32'(k * 4); instr_req = 1; instr_addr = 32'h9000;
      @(negedge clk); chk("g_data_wins", mem_addr_o, 32'h8000 + 32'(k * 4)); instr_req = 0;
      @(negedge clk); data_req = 0;
    end
    @(negedge clk); data_req = 1; data_addr = 32'h8100; instr_req = 1;
    @(negedge clk);
    chk("g_fetch_wins", mem_addr_o, 32'h9000);
    chk("g_fetch_wr", mem_wr_o, 0);
    data_req = 0;
    @(negedge clk);
    chk("g_iack", instr_ack_o, 1);
    instr_req = 0; mem_ack = 0;
    repeat (2) @(negedge clk);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(599) == 0);
      if (instr_req) begin
        if (e_iack) instr_req = 1'($urandom_range(1));
        else if ($urandom_range(19) == 0) instr_req = 0;
      end else instr_req = ($urandom_range(2) == 0);
      if ($urandom_range(3) == 0) instr_addr = $urandom;
      if (data_req) begin
        if (e_dack) data_req = 1'($urandom_range(1));
        else if ($urandom_range(19) == 0) data_req = 0;
      end else data_req = ($urandom_range(2) == 0);
      if ($urandom_range(3) == 0) begin
        data_addr = $urandom; data_wd = $urandom; data_wr = 1'($urandom_range(1));
        r = $urandom_range(2);
        data_be = (r == 2) ? 2'b11 : 2'(r);
      end
      case ((c / 400) % 3)
        0:       mem_ack = 1'($urandom_range(1));
        1:       mem_ack = ($urandom_range(11) == 0);
        default: mem_ack = ($urandom_range(3) == 0);
      endcase
      mem_rd = $urandom;
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
